shift_seq: RTL and testbench
============================

# shift_seq

Multi-cycle shift sequencer for the CPU datapath's shift unit. Accepts one shift command from the main control FSM, drives `ShiftSrcControl` of the shift-source mux, captures the selected operand (`ShiftSrc_out`), and performs the shift. In the default build it shifts one bit position per cycle. It then returns the result with a one-cycle `done` pulse. It replaces the ad-hoc shift sequencing states in the main control unit.

## Interface
No parameters; all widths fixed (32-bit datapath, 5-bit amount).
- `clk` in 1 — sole clock, rising edge
- `reset` in 1 — asynchronous, active-low (asserted at 0)
- `start` in 1 — command strobe, sampled only in IDLE
- `op` in 3 — 000 SLL, 001 SRL, 010 SRA, 011 SLLV, 100 SRLV, 101 SRAV, 110 LUI, 111 illegal
- `shamt` in 5 — instruction shamt field, used by SLL/SRL/SRA
- `RegA_out` in 32 — rs; bits [4:0] give the amount for SLLV/SRLV/SRAV
- `ShiftSrc_out` in 32 — output of the shift-source mux
- `ShiftSrcControl` out 2 — mux select (00 rt, 01 rs, 10 SL16_32)
- `busy` out 1 — high in every state except IDLE
- `done` out 1 — one-cycle completion pulse
- `err` out 1 — one-cycle pulse coincident with `done` for an illegal op
- `shift_result` out 32 — last completed result

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE + `start`=1:
  - latch op kind (left / logical right / arithmetic right)
  - latch amount: `shamt` for ops 000–010, `RegA_out[4:0]` for ops 011–101, 16 for LUI
  - set `ShiftSrcControl`: 00 for ops 000–101, 10 for LUI
  - go to LOAD
- IDLE + `start` with op=111: go directly to DONE with `err`=1. `ShiftSrcControl`, `shift_result` and the internal register are unchanged.
- LOAD: capture `ShiftSrc_out` into the internal shift register and load the down-counter with the amount. If amount=0, go to DONE; otherwise go to SHIFT.
- SHIFT, one bit per cycle:
  - left: fill with 0
  - logical right: fill with 0
  - arithmetic right: replicate bit 31
  - decrement the counter each cycle; when the counter reaches 0, go to DONE
- DONE: `done`=1 for exactly one cycle, `shift_result` equals the internal register, then go to IDLE.
- `start` outside IDLE is ignored; there is no queuing.
- Selector encoding 01 (rs) is reserved; this block never drives it.
- `ShiftSrcControl` and `shift_result` hold their values until the next accepted command.

## Timing
- Reset value of every output is 0: `ShiftSrcControl`=00, `busy`=0, `done`=0, `err`=0, `shift_result`=0. State resets to IDLE and the counter to 0.
- Reset asserted mid-operation aborts immediately. The first `start` accepted after deassertion begins a fresh command.
- `start` is accepted at edge E0.
- `ShiftSrcControl` is valid from after E0. The mux output must be stable by E1, where LOAD samples it.
- Serial build latency: `done` is high in cycle N+2 after E0, where N = amount (0..31).
  - N=0: `done` in cycle 2
  - N=31: `done` in cycle 33
- Illegal op: `done`/`err` are high in cycle 1 after E0.
- `busy` rises after E0 and falls after the DONE cycle. A new `start` is accepted in the cycle after `done`.
- All shift arithmetic is 32-bit. No shift of 32 or more is possible (5-bit amount).

## Configuration
- `SHIFT_SEQ_FAST_EN` defined:
  - SHIFT performs the full N-bit shift in one cycle (barrel shift, same fill rules)
  - nonzero N: `done` is high in cycle 3
  - N=0: behaviour unchanged, skips SHIFT, `done` in cycle 2
- `SHIFT_SEQ_FAST_EN` undefined: the serial one-bit-per-cycle behaviour above applies.

## Test plan
- Reset:
  - `reset`=0 mid-SHIFT of a 20-bit SRL → all outputs 0 at once
  - after release, SLL with `ShiftSrc_out`=0x00000001, `shamt`=4 → `shift_result`=0x00000010, `done` in cycle 6
- SRA: `ShiftSrc_out`=0x80000000, `shamt`=31 → `shift_result`=0xFFFFFFFF, `done` in cycle 33 (cycle 3 with FAST)
- SRLV: `RegA_out`=0x00000024 (amount 4), `ShiftSrc_out`=0xF0000000 → `shift_result`=0x0F000000, `ShiftSrcControl`=00
- LUI: `ShiftSrc_out`=0x00001234 → `ShiftSrcControl`=10, `shift_result`=0x12340000, `done` in cycle 18
- Edge cases:
  - amount 0 SLL of 0xDEADBEEF → result 0xDEADBEEF, `done` in cycle 2
  - op=111 → `done`=`err`=1 in cycle 1, `shift_result` unchanged
- Busy: `start` pulsed during SHIFT → ignored; result and latency of the running command unaffected

Source files
------------

// File: rtl/shift_seq_if.sv
// Command/result bundle between the control FSM and the shift sequencer.
// The master drives the command and the mux output; the slave returns select, status and result.
interface shift_seq_if;
  logic        start;
  logic [2:0]  op;
  logic [4:0]  shamt;
  logic [31:0] RegA_out;
  logic [31:0] ShiftSrc_out;
  logic [1:0]  ShiftSrcControl;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] shift_result;

  modport master (
    output start, op, shamt, RegA_out, ShiftSrc_out,
    input  ShiftSrcControl, busy, done, err, shift_result
  );

  modport slave (
    input  start, op, shamt, RegA_out, ShiftSrc_out,
    output ShiftSrcControl, busy, done, err, shift_result
  );
endinterface

// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer: IDLE -> LOAD -> SHIFT -> DONE, one bit per cycle by default.
// Define SHIFT_SEQ_FAST_EN to perform the whole shift in a single SHIFT cycle.
module shift_seq (
  input  logic          clk,
  input  logic          reset,
  shift_seq_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    K_LEFT = 2'd0,
    K_LSR  = 2'd1,
    K_ASR  = 2'd2
  } kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic [4:0]  amt_q, amt_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] sreg_q, sreg_d;
  logic [31:0] res_q, res_d;
  logic [1:0]  sel_q, sel_d;
  logic        err_q, err_d;
  logic [31:0] shifted;

`ifdef SHIFT_SEQ_FAST_EN
  always_comb begin
    shifted = sreg_q;
    case (kind_q)
      K_LEFT:  shifted = sreg_q << cnt_q;
      K_LSR:   shifted = sreg_q >> cnt_q;
      K_ASR:   shifted = $unsigned($signed(sreg_q) >>> cnt_q);
      default: shifted = sreg_q;
    endcase
  end
`else
  always_comb begin
    shifted = sreg_q;
    case (kind_q)
      K_LEFT:  shifted = {sreg_q[30:0], 1'b0};
      K_LSR:   shifted = {1'b0, sreg_q[31:1]};
      K_ASR:   shifted = {sreg_q[31], sreg_q[31:1]};
      default: shifted = sreg_q;
    endcase
  end
`endif

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    amt_d   = amt_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    res_d   = res_q;
    sel_d   = sel_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.op == 3'b111) begin
            // Illegal op reports straight away and leaves select/result untouched.
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d = 1'b0;
            case (bus.op)
              3'b001, 3'b100: kind_d = K_LSR;
              3'b010, 3'b101: kind_d = K_ASR;
              default:        kind_d = K_LEFT;
            endcase
            if (bus.op <= 3'b010)      amt_d = bus.shamt;
            else if (bus.op <= 3'b101) amt_d = bus.RegA_out[4:0];
            else                       amt_d = 5'd16;
            sel_d   = (bus.op == 3'b110) ? 2'b10 : 2'b00;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        sreg_d = bus.ShiftSrc_out;
        cnt_d  = amt_q;
        if (amt_q == 5'd0) begin
          res_d   = bus.ShiftSrc_out;
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sreg_d = shifted;
`ifdef SHIFT_SEQ_FAST_EN
        cnt_d   = 5'd0;
        res_d   = shifted;
        state_d = ST_DONE;
`else
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          res_d   = shifted;
          state_d = ST_DONE;
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      kind_q  <= K_LEFT;
      amt_q   <= 5'd0;
      cnt_q   <= 5'd0;
      sreg_q  <= 32'd0;
      res_q   <= 32'd0;
      sel_q   <= 2'b00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      amt_q   <= amt_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      res_q   <= res_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  assign bus.ShiftSrcControl = sel_q;
  assign bus.busy            = (state_q != ST_IDLE);
  assign bus.done            = (state_q == ST_DONE);
  assign bus.err             = (state_q == ST_DONE) && err_q;
  assign bus.shift_result    = res_q;

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq: latency, result, select and status per command, plus reset abort.
module tb_shift_seq;
`ifdef SHIFT_SEQ_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  shift_seq_if bus ();
  shift_seq dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  function automatic int lat(int n);
    if (n == 0) return 2;
    return FAST ? 3 : n + 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [4:0] sh,
                         input logic [31:0] rega, input logic [31:0] src,
                         input logic [31:0] exp_res, input int exp_cyc,
                         input logic [1:0] exp_sel, input logic exp_err, input int pulse_at);
    int got = -1;
    logic got_err = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.shamt = sh;
    bus.RegA_out = rega; bus.ShiftSrc_out = src;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start = 1'b0;
        chk({tag, " sel"}, {30'd0, bus.ShiftSrcControl}, {30'd0, exp_sel});
        chk({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
      end
      if (k == pulse_at) begin
        bus.start = 1'b1; bus.op = 3'b111; bus.shamt = 5'd1;
      end
      if (k == pulse_at + 1) bus.start = 1'b0;
      if (bus.done) begin
        got = k;
        got_err = bus.err;
        break;
      end
    end
    chk({tag, " done cycle"}, got, exp_cyc);
    chk({tag, " result"}, bus.shift_result, exp_res);
    chk({tag, " err"}, {31'd0, got_err}, {31'd0, exp_err});
    @(negedge clk);
    chk({tag, " done pulse width"}, {31'd0, bus.done}, 32'd0);
    chk({tag, " busy after"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 3'b000; bus.shamt = 5'd0;
    bus.RegA_out = 32'd0; bus.ShiftSrc_out = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset sel", {30'd0, bus.ShiftSrcControl}, 32'd0);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset err", {31'd0, bus.err}, 32'd0);
    chk("reset result", bus.shift_result, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_cmd("LUI", 3'b110, 5'd3, 32'd0, 32'h0000_1234, 32'h1234_0000, lat(16), 2'b10, 1'b0, 0);

    // SRL by 20, then async reset while still shifting
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b001; bus.shamt = 5'd20; bus.ShiftSrc_out = 32'hFFFF_0000;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("pre-abort busy", {31'd0, bus.busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort sel", {30'd0, bus.ShiftSrcControl}, 32'd0);
    chk("abort busy", {31'd0, bus.busy}, 32'd0);
    chk("abort done", {31'd0, bus.done}, 32'd0);
    chk("abort err", {31'd0, bus.err}, 32'd0);
    chk("abort result", bus.shift_result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post-abort idle", {31'd0, bus.busy}, 32'd0);

    run_cmd("SLL4", 3'b000, 5'd4, 32'd0, 32'h0000_0001, 32'h0000_0010, lat(4), 2'b00, 1'b0, 0);
    run_cmd("SRA31", 3'b010, 5'd31, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, lat(31), 2'b00, 1'b0, 0);
    run_cmd("SRLV", 3'b100, 5'd7, 32'h0000_0024, 32'hF000_0000, 32'h0F00_0000, lat(4), 2'b00, 1'b0, 0);
    run_cmd("SRAV", 3'b101, 5'd9, 32'h0000_0003, 32'h8000_0000, 32'hF000_0000, lat(3), 2'b00, 1'b0, 0);
    run_cmd("SLLV", 3'b011, 5'd0, 32'hFFFF_FFE1, 32'h8000_0003, 32'h0000_0006, lat(1), 2'b00, 1'b0, 0);
    run_cmd("LUI2", 3'b110, 5'd0, 32'd0, 32'h0000_ABCD, 32'hABCD_0000, lat(16), 2'b10, 1'b0, 0);
    run_cmd("SLL0", 3'b000, 5'd0, 32'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, lat(0), 2'b00, 1'b0, 0);
    run_cmd("ILLEGAL", 3'b111, 5'd5, 32'd0, 32'h1111_1111, 32'hDEAD_BEEF, 1, 2'b00, 1'b1, 0);
    run_cmd("SRL8 busy", 3'b001, 5'd8, 32'd0, 32'h8000_0000, 32'h0080_0000, lat(8), 2'b00, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
